// File: rtl/cpt_dec.sv
//==============================================================================
// Module      : cpt_dec
// Description : Loadable binary down-counter with expiry pulse, one-shot or
//               periodic auto-reload operation.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cpt_dec #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             activate,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             reload,
  output logic [WIDTH-1:0] cpt,
  output logic             zero,
  output logic             expired,
  output logic [1:0]       state
);

  localparam logic [1:0]       c_st_idle    = 2'd0;
  localparam logic [1:0]       c_st_run     = 2'd1;
  localparam logic [1:0]       c_st_expired = 2'd2;
  localparam logic [WIDTH-1:0] c_max        = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] c_zero       = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] c_one        = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_cpt;
  logic [WIDTH-1:0] r_rld;
  logic             r_expired;

  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] w_cpt_nxt;
  logic [WIDTH-1:0] w_rld_nxt;
  logic             w_expired_nxt;

  // State, count, reload value and expiry pulse register together
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= c_st_idle;
      r_cpt     <= c_max;
      r_rld     <= c_max;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cpt     <= w_cpt_nxt;
      r_rld     <= w_rld_nxt;
      r_expired <= w_expired_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cpt_nxt     = r_cpt;
    w_rld_nxt     = r_rld;
    w_expired_nxt = 1'b0;
    if (load) begin
      w_cpt_nxt   = load_val;
      w_rld_nxt   = load_val;
      w_state_nxt = c_st_idle;
    end else begin
      case (r_state)
        c_st_idle, c_st_run: begin
          if (!activate) begin
            w_state_nxt = c_st_idle;
          end else if (r_cpt > c_one) begin
            w_cpt_nxt   = r_cpt - c_one;
            w_state_nxt = c_st_run;
          end else if (r_cpt == c_one) begin
            w_cpt_nxt     = c_zero;
            w_state_nxt   = c_st_expired;
            w_expired_nxt = 1'b1;
          end else begin
            // Count already 0 after a load of 0: expire silently
            w_state_nxt = c_st_expired;
          end
        end
        c_st_expired: begin
          if (activate && reload && (r_rld != c_zero)) begin
            w_cpt_nxt   = r_rld;
            w_state_nxt = c_st_run;
          end
        end
        default: w_state_nxt = c_st_idle;
      endcase
    end
  end

  always_comb begin
    cpt     = r_cpt;
    zero    = (r_cpt == c_zero);
    expired = r_expired;
    state   = r_state;
  end

endmodule

`default_nettype wire

// File: tb/tb_cpt_dec.sv
//==============================================================================
// Module      : tb_cpt_dec
// Description : Self-checking bench for cpt_dec: vector table, corner-case
//               sequences and randomized run against a reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_cpt_dec;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       activate = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'd0;
  logic       reload = 1'b0;
  logic [7:0] cpt;
  logic       zero;
  logic       expired;
  logic [1:0] state;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int m_cpt, m_rld, m_st;
  bit m_exp;

  typedef struct {
    bit       rst;
    bit       ld;
    int       lv;
    bit       act;
    bit       rl;
    int       e_cpt;
    bit       e_zero;
    bit       e_exp;
    int       e_st;
  } vec_t;

  vec_t vecs[15];

  cpt_dec #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .activate (activate),
    .load     (load),
    .load_val (load_val),
    .reload   (reload),
    .cpt      (cpt),
    .zero     (zero),
    .expired  (expired),
    .state    (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit l, input int lv, input bit a, input bit rl);
    reset    = r;
    load     = l;
    load_val = 8'(lv);
    activate = a;
    reload   = rl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Spec rules applied to one edge
  task automatic model(input bit r, input bit l, input int lv, input bit a, input bit rl);
    m_exp = 0;
    if (r) begin
      m_cpt = 255; m_rld = 255; m_st = 0;
    end else if (l) begin
      m_cpt = lv; m_rld = lv; m_st = 0;
    end else if (m_st == 2) begin
      if (a && rl && m_rld != 0) begin
        m_cpt = m_rld; m_st = 1;
      end
    end else if (!a) begin
      m_st = 0;
    end else if (m_cpt == 0) begin
      m_st = 2;
    end else begin
      m_cpt = m_cpt - 1;
      m_exp = (m_cpt == 0);
      m_st  = (m_cpt == 0) ? 2 : 1;
    end
  endtask

  initial begin
    int prev;
    int pulses;

    //            rst ld lv   act rl  cpt  z  e  st
    vecs[0]  = '{1, 0, 0,   0, 0,  255, 0, 0, 0};
    vecs[1]  = '{0, 1, 3,   0, 0,  3,   0, 0, 0};
    vecs[2]  = '{0, 0, 0,   1, 0,  2,   0, 0, 1};
    vecs[3]  = '{0, 0, 0,   1, 0,  1,   0, 0, 1};
    vecs[4]  = '{0, 0, 0,   1, 0,  0,   1, 1, 2};
    vecs[5]  = '{0, 0, 0,   1, 0,  0,   1, 0, 2};
    vecs[6]  = '{0, 1, 2,   0, 1,  2,   0, 0, 0};
    vecs[7]  = '{0, 0, 0,   1, 1,  1,   0, 0, 1};
    vecs[8]  = '{0, 0, 0,   1, 1,  0,   1, 1, 2};
    vecs[9]  = '{0, 0, 0,   1, 1,  2,   0, 0, 1};
    vecs[10] = '{0, 0, 0,   0, 1,  2,   0, 0, 0};
    vecs[11] = '{0, 1, 0,   1, 1,  0,   1, 0, 0};
    vecs[12] = '{0, 0, 0,   1, 1,  0,   1, 0, 2};
    vecs[13] = '{0, 0, 0,   1, 1,  0,   1, 0, 2};
    vecs[14] = '{1, 1, 7,   1, 1,  255, 0, 0, 0};

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].rst, vecs[i].ld, vecs[i].lv, vecs[i].act, vecs[i].rl);
      step();
      chk($sformatf("vec%0d_cpt", i), int'(cpt), vecs[i].e_cpt);
      chk($sformatf("vec%0d_zero", i), int'(zero), int'(vecs[i].e_zero));
      chk($sformatf("vec%0d_exp", i), int'(expired), int'(vecs[i].e_exp));
      chk($sformatf("vec%0d_state", i), int'(state), vecs[i].e_st);
    end

    // Full countdown from reset, strictly monotonic
    drive(1, 0, 0, 0, 0); step();
    chk("s1_reset_cpt", int'(cpt), 255);
    chk("s1_reset_zero", int'(zero), 0);
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 255; i++) begin
      prev = int'(cpt);
      step();
      chk("s1_dec", int'(cpt), prev - 1);
      chk("s1_exp", int'(expired), (i == 254) ? 1 : 0);
    end
    step();
    chk("s1_hold_cpt", int'(cpt), 0);
    chk("s1_hold_exp", int'(expired), 0);
    chk("s1_hold_state", int'(state), 2);

    // Periodic: load 5, period 6
    drive(0, 1, 5, 1, 1); step();
    chk("s3_load", int'(cpt), 5);
    drive(0, 0, 0, 1, 1);
    pulses = 0;
    for (int k = 1; k <= 18; k++) begin
      step();
      chk("s3_cpt", int'(cpt), 5 - (k % 6));
      chk("s3_exp", int'(expired), (k % 6 == 5) ? 1 : 0);
      pulses += int'(expired);
    end
    chk("s3_pulses", pulses, 3);

    // Activate gap pauses the count
    drive(0, 1, 10, 0, 0); step();
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step();
    chk("s4_cpt7", int'(cpt), 7);
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("s4_pause_cpt", int'(cpt), 7);
      chk("s4_pause_state", int'(state), 0);
    end
    drive(0, 0, 0, 1, 0); step();
    chk("s4_resume", int'(cpt), 6);

    // Load beats activate; reset beats everything
    drive(0, 1, 6, 0, 0); step();
    drive(0, 0, 0, 1, 0); step(); step();
    chk("s5_cpt4", int'(cpt), 4);
    drive(0, 1, 9, 1, 0); step();
    chk("s5_load_cpt", int'(cpt), 9);
    chk("s5_load_state", int'(state), 0);
    drive(0, 0, 0, 1, 0); step(); step();
    chk("s5_cpt7", int'(cpt), 7);
    drive(1, 1, 3, 1, 1); step();
    chk("s5_rst_cpt", int'(cpt), 255);
    chk("s5_rst_exp", int'(expired), 0);
    chk("s5_rst_state", int'(state), 0);

    // Load 0 never pulses, even periodic
    drive(0, 1, 0, 1, 1); step();
    chk("s6_zero", int'(zero), 1);
    drive(0, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("s6_cpt", int'(cpt), 0);
      chk("s6_state", int'(state), 2);
      chk("s6_noexp", int'(expired), 0);
    end
    drive(0, 1, 1, 0, 1); step();
    chk("s6_load1", int'(cpt), 1);
    drive(0, 0, 0, 1, 0); step();
    chk("s6_cpt0", int'(cpt), 0);
    chk("s6_exp", int'(expired), 1);

    // Randomized run against the model
    drive(1, 0, 0, 0, 0); step();
    model(1, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      bit r, l, a, rl;
      int lv;
      r  = ($urandom_range(0, 199) == 0);
      l  = ($urandom_range(0, 19) == 0);
      lv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 8));
      a  = ($urandom_range(0, 9) < 7);
      rl = $urandom_range(0, 1) == 1;
      drive(r, l, lv, a, rl);
      step();
      model(r, l, lv, a, rl);
      chk("rnd_cpt", int'(cpt), m_cpt);
      chk("rnd_zero", int'(zero), (m_cpt == 0) ? 1 : 0);
      chk("rnd_exp", int'(expired), int'(m_exp));
      chk("rnd_state", int'(state), m_st);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
